iter_shifter: RTL

- Parametrised multicycle shifter for the ALU datapath; successor to the combinational shift unit.
- Accepts one operation per start/done handshake and shifts by up to STEP bit positions per clock.
- Supports LSL, LSR, ASR, ROR and RRX with carry-out.
- The controller FSM issues start and waits on done.

---
 rtl/iter_shifter.sv | 179 +++++++++++++++++
 1 files changed

// File: rtl/iter_shifter.sv
// Multicycle shifter: LSL/LSR/ASR/ROR/RRX, up to STEP bit positions per clock, start/done handshake.
// Optional SHIFT_FLAGS_EN adds registered zero_flag and neg_flag outputs.
module iter_shifter #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned STEP  = 4,
  parameter int unsigned AMT_W = $clog2(WIDTH) + 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [2:0]       cmd,
  input  logic [WIDTH-1:0] data_in,
  input  logic [AMT_W-1:0] amount,
  input  logic             carry_in,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] data_out,
`ifdef SHIFT_FLAGS_EN
  output logic             zero_flag,
  output logic             neg_flag,
`endif
  output logic             carry_out
);

  localparam logic [2:0] CMD_LSL = 3'b000;
  localparam logic [2:0] CMD_LSR = 3'b001;
  localparam logic [2:0] CMD_ASR = 3'b010;
  localparam logic [2:0] CMD_ROR = 3'b011;
  localparam logic [2:0] CMD_RRX = 3'b100;

  localparam logic [AMT_W-1:0] W_AMT    = AMT_W'(WIDTH);
  localparam logic [AMT_W-1:0] WP1_AMT  = AMT_W'(WIDTH + 1);
  localparam logic [AMT_W-1:0] STEP_AMT = AMT_W'(STEP);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t           state, state_next;
  logic [2:0]       op;
  logic [AMT_W-1:0] rem;
  logic             ror_full;

  logic [AMT_W-1:0] n_c;
  logic             full_c;
  logic             accept_c;
  logic [AMT_W-1:0] step_c;
  logic [AMT_W-1:0] rem_next_c;
  logic [WIDTH-1:0] shift_d_c;
  logic             shift_cy_c;
  logic [WIDTH-1:0] data_nxt_c;
  logic             carry_nxt_c;

  // Effective shift count for the operation presented at the inputs.
  always_comb begin
    n_c    = '0;
    full_c = 1'b0;
    case (cmd)
      CMD_LSL, CMD_LSR: n_c = (amount > WP1_AMT) ? WP1_AMT : amount;
      CMD_ASR:          n_c = (amount > W_AMT) ? W_AMT : amount;
      CMD_ROR: begin
        n_c    = amount % W_AMT;
        full_c = (amount != '0) && (n_c == '0);
      end
      CMD_RRX:          n_c = AMT_W'(1);
      default:          n_c = '0;
    endcase
  end

  always_comb begin
    step_c     = (rem < STEP_AMT) ? rem : STEP_AMT;
    rem_next_c = rem - step_c;
  end

  // Chain of STEP single-bit stages; stage i is active when i < step_c.
  always_comb begin
    shift_d_c  = data_out;
    shift_cy_c = carry_out;
    for (int i = 0; i < int'(STEP); i++) begin
      if (AMT_W'(i) < step_c) begin
        case (op)
          CMD_LSL: begin
            shift_cy_c = shift_d_c[WIDTH-1];
            shift_d_c  = {shift_d_c[WIDTH-2:0], 1'b0};
          end
          CMD_LSR: begin
            shift_cy_c = shift_d_c[0];
            shift_d_c  = {1'b0, shift_d_c[WIDTH-1:1]};
          end
          CMD_ASR: begin
            shift_cy_c = shift_d_c[0];
            shift_d_c  = {shift_d_c[WIDTH-1], shift_d_c[WIDTH-1:1]};
          end
          CMD_ROR: begin
            shift_cy_c = shift_d_c[0];
            shift_d_c  = {shift_d_c[0], shift_d_c[WIDTH-1:1]};
          end
          CMD_RRX: begin
            shift_d_c  = {shift_cy_c, shift_d_c[WIDTH-1:1]};
            shift_cy_c = data_out[0];
          end
          default: begin
            shift_d_c  = shift_d_c;
            shift_cy_c = shift_cy_c;
          end
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    accept_c   = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          accept_c   = 1'b1;
          state_next = ((n_c != '0) || full_c) ? SHIFT : DONE;
        end
      end
      SHIFT: if (rem_next_c == '0) state_next = DONE;
      DONE:  state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Result register is also the working register; a full-width ROR keeps data and reports the MSB.
  always_comb begin
    data_nxt_c  = data_out;
    carry_nxt_c = carry_out;
    if (accept_c) begin
      data_nxt_c  = data_in;
      carry_nxt_c = carry_in;
    end else if (state == SHIFT) begin
      data_nxt_c  = shift_d_c;
      carry_nxt_c = ror_full ? data_out[WIDTH-1] : shift_cy_c;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      busy      <= 1'b0;
      done      <= 1'b0;
      data_out  <= '0;
      carry_out <= 1'b0;
      op        <= '0;
      rem       <= '0;
      ror_full  <= 1'b0;
    end else begin
      busy      <= (state_next != IDLE);
      done      <= (state_next == DONE);
      data_out  <= data_nxt_c;
      carry_out <= carry_nxt_c;
      if (accept_c) begin
        op       <= cmd;
        rem      <= n_c;
        ror_full <= full_c;
      end else if (state == SHIFT) begin
        rem <= rem_next_c;
      end
    end
  end

`ifdef SHIFT_FLAGS_EN
  always_ff @(posedge clk) begin
    if (!reset) begin
      zero_flag <= 1'b0;
      neg_flag  <= 1'b0;
    end else begin
      zero_flag <= (data_nxt_c == '0);
      neg_flag  <= data_nxt_c[WIDTH-1];
    end
  end
`endif

endmodule
